// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use / branch stall, flush and data-memory wait/timeout control
// Optional feature macro: HAZARD_STALL_COUNTER_EN (adds the saturating stall_cycles counter)
module hazard_detection_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs1,
  input  logic [4:0] ID_Rs2,
  input  logic       ID_UsesRs1,
  input  logic       ID_UsesRs2,
  input  logic       ID_IsBranch,
  input  logic       branch_taken,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_Rd,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_Rd,
  input  logic       MEM_MemAccess,
  input  logic       dmem_ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       Pipe_Freeze,
  output logic       mem_timeout
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // Counter only has to reach MEM_TIMEOUT, so it is sized to hold exactly that.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  logic          freeze;
  logic          load_use;
  logic          br_stall;
  logic          stall;
  logic          rs1_ex_hit;
  logic          rs2_ex_hit;
  logic          rs1_exw_hit;
  logic          rs2_exw_hit;
  logic          rs1_meml_hit;
  logic          rs2_meml_hit;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state: enter wait on a stalled access, leave on ready, fault on timeout
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (MEM_MemAccess && !dmem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        // A late ready always beats the timeout compare.
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          state_next    = FAULT;
        end else begin
          wait_cnt_next = wait_cnt + CNT_ONE;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Source/destination comparisons; x0 never creates a dependency
  always_comb begin
    rs1_ex_hit   = ID_UsesRs1 && (EX_Rd != 5'd0) && (ID_Rs1 == EX_Rd);
    rs2_ex_hit   = ID_UsesRs2 && (EX_Rd != 5'd0) && (ID_Rs2 == EX_Rd);
    rs1_exw_hit  = rs1_ex_hit && EX_RegWrite;
    rs2_exw_hit  = rs2_ex_hit && EX_RegWrite;
    rs1_meml_hit = ID_UsesRs1 && MEM_MemRead && (MEM_Rd != 5'd0) && (ID_Rs1 == MEM_Rd);
    rs2_meml_hit = ID_UsesRs2 && MEM_MemRead && (MEM_Rd != 5'd0) && (ID_Rs2 == MEM_Rd);
  end

  // Hazard classification; freeze dominates any stall
  always_comb begin
    freeze   = 1'b0;
    case (state)
      RUN:      freeze = MEM_MemAccess && !dmem_ready;
      MEM_WAIT: freeze = !dmem_ready;
      FAULT:    freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
    // A load in EX cannot forward to anyone in ID yet.
    load_use = EX_MemRead && (rs1_ex_hit || rs2_ex_hit);
    // The branch ALU sits in ID, so it also waits for EX results and MEM-stage load data;
    // MEM-stage ALU results are forwarded.
    br_stall = ID_IsBranch && (rs1_exw_hit || rs2_exw_hit || rs1_meml_hit || rs2_meml_hit);
    stall    = (load_use || br_stall) && !freeze;
  end

  // Pipeline control outputs, forced neutral while reset is held
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    mem_timeout  = (state == FAULT);
    if (!rst) begin
      PC_Write     = !(freeze || stall);
      IF_ID_Write  = !(freeze || stall);
      ID_EX_Bubble = stall;
      IF_ID_Flush  = ID_IsBranch && branch_taken && !stall && !freeze;
      Pipe_Freeze  = freeze;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  // Saturating count of cycles lost to stalls or freezes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if ((stall || freeze) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
